// File: rtl/te_pkg.sv
// Shared constants and helpers for the transmission-estimation pipeline.
//   LATENCY   : cycles from input accept to output valid when never stalled
//   DEF_LW    : default reciprocal LUT entry width
//   DEF_FRAC  : fractional bits of a LUT entry (entry k = round(2^DEF_FRAC/(k+1)))
//   DEF_SHIFT : default right shift applied to the selected product
//   min_ch_w  : width of the min-channel index (clog2 with a floor of 1)
package te_pkg;

  localparam int unsigned LATENCY   = 4;
  localparam int unsigned DEF_LW    = 12;
  localparam int unsigned DEF_FRAC  = DEF_LW - 1;
  localparam int unsigned DEF_SHIFT = 9;

  function automatic int unsigned min_ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/te_recip_lut.sv
// One read copy of the reciprocal LUT: 1W/1R synchronous RAM, read-first.
//   clk_i   : clock
//   we_i    : write strobe, accepted every cycle
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable (registered read data only advances when set)
//   raddr_i : read address
//   rdata_o : registered read data
// Contents are deliberately not reset so a loaded table survives a pipeline reset.
module te_recip_lut #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Both updates are non-blocking, so a same-edge read of a written address sees old data.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/te_recip_pipe.sv
// Transmission-estimation pipeline: per pixel, 1/t = min_c (A_c * LUT[A_c - Idark - 1]) >> SHIFT,
// saturated to OMAX, plus the index of the minimum channel.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_valid/o_ready         : input handshake (o_ready = pipeline enable)
//   i_dark, i_atm           : dark-channel value and per-channel airlight (channel 0 in LSBs)
//   o_valid/i_ready         : output handshake
//   o_one_by_t, o_min_ch    : saturated 1/t and selected channel
//   i_lut_we/addr/wdata     : reciprocal LUT write port, shared by all channel copies
// Stages: S1 subtract/address, S2 LUT read, S3 multiply, S4 min/shift/clamp.
module te_recip_pipe
  import te_pkg::*;
#(
  parameter int unsigned PW    = 8,
  parameter int unsigned NCH   = 3,
  parameter int unsigned LW    = DEF_LW,
  parameter int unsigned SHIFT = DEF_SHIFT,
  parameter int unsigned OW    = 11,
  parameter int unsigned OMAX  = (2 ** OW) - 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [PW-1:0]              i_dark,
  input  logic [NCH*PW-1:0]          i_atm,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [OW-1:0]              o_one_by_t,
  output logic [min_ch_w(NCH)-1:0]   o_min_ch,
  input  logic                       i_lut_we,
  input  logic [PW-1:0]              i_lut_addr,
  input  logic [LW-1:0]              i_lut_wdata
);

  localparam int unsigned CW     = min_ch_w(NCH);
  localparam int unsigned PROD_W = PW + LW;

  logic en;

  // S1
  logic                      v1_q, v1_d;
  logic [NCH-1:0][PW-1:0]    addr1_q, addr1_d;
  logic [NCH-1:0][PW-1:0]    a1_q, a1_d;
  logic [NCH-1:0]            z1_q, z1_d;
  // S2 (LUT data lives in the LUT read registers)
  logic                      v2_q, v2_d;
  logic [NCH-1:0][PW-1:0]    a2_q, a2_d;
  logic [NCH-1:0]            z2_q, z2_d;
  logic [NCH-1:0][LW-1:0]    lut_rd;
  // S3
  logic                      v3_q, v3_d;
  logic [NCH-1:0][PROD_W-1:0] prod3_q, prod3_d;
  // S4
  logic                      o_valid_q, o_valid_d;
  logic [OW-1:0]             one_by_t_q, one_by_t_d;
  logic [CW-1:0]             min_ch_q, min_ch_d;

  logic [PROD_W-1:0]         min_val;
  logic [CW-1:0]             min_idx;
  logic [PROD_W-1:0]         shifted;
  logic [OW-1:0]             sat_val;

  // Stall-all: everything advances whenever the output register is free or being drained.
  assign en      = i_ready | ~o_valid_q;
  assign o_ready = en;

  for (genvar g = 0; g < NCH; g++) begin : g_lut
    te_recip_lut #(
      .AW (PW),
      .DW (LW)
    ) u_lut (
      .clk_i   (i_clk),
      .we_i    (i_lut_we),
      .waddr_i (i_lut_addr),
      .wdata_i (i_lut_wdata),
      .re_i    (en),
      .raddr_i (addr1_q[g]),
      .rdata_o (lut_rd[g])
    );
  end

  // Linear min search; strict compare keeps the lowest index on ties.
  always_comb begin
    min_val = prod3_q[0];
    min_idx = '0;
    for (int c = 1; c < NCH; c++) begin
      if (prod3_q[c] < min_val) begin
        min_val = prod3_q[c];
        min_idx = CW'(c);
      end
    end
    shifted = min_val >> SHIFT;
    sat_val = (shifted > PROD_W'(OMAX)) ? OW'(OMAX) : shifted[OW-1:0];
  end

  always_comb begin
    v1_d       = v1_q;
    addr1_d    = addr1_q;
    a1_d       = a1_q;
    z1_d       = z1_q;
    v2_d       = v2_q;
    a2_d       = a2_q;
    z2_d       = z2_q;
    v3_d       = v3_q;
    prod3_d    = prod3_q;
    o_valid_d  = o_valid_q;
    one_by_t_d = one_by_t_q;
    min_ch_d   = min_ch_q;
    if (en) begin
      v1_d = i_valid;
      for (int c = 0; c < NCH; c++) begin
        a1_d[c] = i_atm[c*PW +: PW];
        if (i_atm[c*PW +: PW] > i_dark) begin
          addr1_d[c] = i_atm[c*PW +: PW] - i_dark - PW'(1);
          z1_d[c]    = 1'b0;
        end else begin
          addr1_d[c] = '0;
          z1_d[c]    = 1'b1;
        end
      end
      v2_d = v1_q;
      a2_d = a1_q;
      z2_d = z1_q;
      v3_d = v2_q;
      for (int c = 0; c < NCH; c++) begin
        // A_c == Idark (or below) means t -> 0: force the product to its ceiling.
        prod3_d[c] = z2_q[c] ? '1 : PROD_W'(a2_q[c]) * PROD_W'(lut_rd[c]);
      end
      o_valid_d = v3_q;
      if (v3_q) begin
        one_by_t_d = sat_val;
        min_ch_d   = min_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q       <= 1'b0;
      addr1_q    <= '0;
      a1_q       <= '0;
      z1_q       <= '0;
      v2_q       <= 1'b0;
      a2_q       <= '0;
      z2_q       <= '0;
      v3_q       <= 1'b0;
      prod3_q    <= '0;
      o_valid_q  <= 1'b0;
      one_by_t_q <= '0;
      min_ch_q   <= '0;
    end else begin
      v1_q       <= v1_d;
      addr1_q    <= addr1_d;
      a1_q       <= a1_d;
      z1_q       <= z1_d;
      v2_q       <= v2_d;
      a2_q       <= a2_d;
      z2_q       <= z2_d;
      v3_q       <= v3_d;
      prod3_q    <= prod3_d;
      o_valid_q  <= o_valid_d;
      one_by_t_q <= one_by_t_d;
      min_ch_q   <= min_ch_d;
    end
  end

  assign o_valid    = o_valid_q;
  assign o_one_by_t = one_by_t_q;
  assign o_min_ch   = min_ch_q;

endmodule
